// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined WIDTH x WIDTH Urdhva-Tiryagbhyam multiplier, valid/ready flow.
// Define VEDIC_SIGNED_EN to honour in_signed (two's-complement operands); otherwise all unsigned.

module vedic_ripple_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);
    logic [W:0] c;

    assign c[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign co_o = c[W];
endmodule

// Combines four 2H-bit partial products into the exact 4H-bit product.
module vedic_combine #(
    parameter int unsigned H = 4
) (
    input  logic [2*H-1:0] pp0_i,
    input  logic [2*H-1:0] pp1_i,
    input  logic [2*H-1:0] pp2_i,
    input  logic [2*H-1:0] pp3_i,
    output logic [4*H-1:0] p_o
);
    localparam int unsigned W = 4 * H;

    logic [W-1:0] x0, x1, x2, x3;
    logic [W-1:0] mid, low;
    logic [2:0]   unused_co;

    assign x0 = {{(2*H){1'b0}}, pp0_i};
    assign x1 = {{H{1'b0}}, pp1_i, {H{1'b0}}};
    assign x2 = {{H{1'b0}}, pp2_i, {H{1'b0}}};
    assign x3 = {pp3_i, {(2*H){1'b0}}};

    // The full sum is below 2^W, so every carry-out is zero.
    vedic_ripple_add #(.W(W)) u_add_mid (.a_i(x1),  .b_i(x2), .sum_o(mid), .co_o(unused_co[0]));
    vedic_ripple_add #(.W(W)) u_add_low (.a_i(mid), .b_i(x0), .sum_o(low), .co_o(unused_co[1]));
    vedic_ripple_add #(.W(W)) u_add_top (.a_i(low), .b_i(x3), .sum_o(p_o), .co_o(unused_co[2]));
endmodule

// Recursive N x N Vedic multiplier built from 2x2 cells.
module vedic_mul #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    if (N == 2) begin : g_cell
        logic t1, t2, hh, c1;
        assign t1     = a_i[1] & b_i[0];
        assign t2     = a_i[0] & b_i[1];
        assign hh     = a_i[1] & b_i[1];
        assign c1     = t1 & t2;
        assign p_o[0] = a_i[0] & b_i[0];
        assign p_o[1] = t1 ^ t2;
        assign p_o[2] = hh ^ c1;
        assign p_o[3] = hh & c1;
    end else begin : g_rec
        localparam int unsigned H = N / 2;
        logic [N-1:0] pp0, pp1, pp2, pp3;

        vedic_mul #(.N(H)) u_m0 (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(pp0));
        vedic_mul #(.N(H)) u_m1 (.a_i(a_i[H-1:0]), .b_i(b_i[N-1:H]), .p_o(pp1));
        vedic_mul #(.N(H)) u_m2 (.a_i(a_i[N-1:H]), .b_i(b_i[H-1:0]), .p_o(pp2));
        vedic_mul #(.N(H)) u_m3 (.a_i(a_i[N-1:H]), .b_i(b_i[N-1:H]), .p_o(pp3));
        vedic_combine #(.H(H)) u_comb (
            .pp0_i(pp0), .pp1_i(pp1), .pp2_i(pp2), .pp3_i(pp3), .p_o(p_o)
        );
    end
endmodule

module vedic_mult_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int unsigned H = WIDTH / 2;

    logic               adv;
    logic               v1_q, v2_q, v3_q;
    logic [WIDTH-1:0]   a_mag_d, b_mag_d, a_mag_q, b_mag_q;
    logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
    logic [WIDTH-1:0]   pp0_d, pp1_d, pp2_d, pp3_d;
    logic [WIDTH-1:0]   pp0_q, pp1_q, pp2_q, pp3_q;
    logic [2*WIDTH-1:0] p_sum, prod_d, prod_q;

    // One global enable: the whole pipe stalls only when the output is held.
    assign adv      = !v3_q || out_ready;
    assign in_ready = adv;

`ifdef VEDIC_SIGNED_EN
    logic neg_d, neg1_q, neg2_q;

    assign neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    assign a_mag_d = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_mag_d = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign prod_d  = neg2_q ? -p_sum : p_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
        end else if (adv) begin
            neg1_q <= neg_d;
            neg2_q <= neg1_q;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = in_signed;
    assign a_mag_d       = in_a;
    assign b_mag_d       = in_b;
    assign prod_d        = p_sum;
`endif

    vedic_mul #(.N(H)) u_pp0 (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[H-1:0]),     .p_o(pp0_d));
    vedic_mul #(.N(H)) u_pp1 (.a_i(a_mag_q[H-1:0]),     .b_i(b_mag_q[WIDTH-1:H]), .p_o(pp1_d));
    vedic_mul #(.N(H)) u_pp2 (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[H-1:0]),     .p_o(pp2_d));
    vedic_mul #(.N(H)) u_pp3 (.a_i(a_mag_q[WIDTH-1:H]), .b_i(b_mag_q[WIDTH-1:H]), .p_o(pp3_d));

    vedic_combine #(.H(H)) u_comb (
        .pp0_i(pp0_q), .pp1_i(pp1_q), .pp2_i(pp2_q), .pp3_i(pp3_q), .p_o(p_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            pp0_q   <= '0;
            pp1_q   <= '0;
            pp2_q   <= '0;
            pp3_q   <= '0;
            prod_q  <= '0;
        end else if (adv) begin
            v1_q    <= in_valid;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            tag1_q  <= in_tag;
            v2_q    <= v1_q;
            tag2_q  <= tag1_q;
            pp0_q   <= pp0_d;
            pp1_q   <= pp1_d;
            pp2_q   <= pp2_d;
            pp3_q   <= pp3_d;
            v3_q    <= v2_q;
            tag3_q  <= tag2_q;
            prod_q  <= prod_d;
        end
    end

    assign out_valid = v3_q;
    assign out_prod  = prod_q;
    assign out_tag   = tag3_q;
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Self-checking bench for vedic_mult_pipe: a 16-bit instance for flow control and an
// 8-bit instance for the signed/unsigned operand cases (follows VEDIC_SIGNED_EN).
module tb_vedic_mult_pipe;
`ifdef VEDIC_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] out_prod;

    logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
    logic [7:0]  in_a8, in_b8;
    logic [3:0]  in_tag8, out_tag8;
    logic [15:0] out_prod8;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];

    always #5 clk = ~clk;

    vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
    );

    vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8),
        .in_b(in_b8), .in_signed(in_signed8), .in_tag(in_tag8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out_prod(out_prod8), .out_tag(out_tag8)
    );

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        int sa, sb;
        if (SIGNED_EN && s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        return 16'(sa * sb);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'h0003;
        in_b = 16'h0005;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_prod !== 32'd0) begin
            n_err++; $display("FAIL reset_out_prod: got %h want 0", out_prod);
        end
        n_cmp++;
        if (out_tag !== 4'd0) begin
            n_err++; $display("FAIL reset_out_tag: got %h want 0", out_tag);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        // The op offered while rst was high must never emerge.
        repeat (6) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_no_accept: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] a_t [2] = '{16'hFFFF, 16'h1234};
        logic [15:0] b_t [2] = '{16'hFFFF, 16'h5678};
        logic [31:0] e_t [2] = '{32'hFFFE0001, 32'h06260060};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = a_t[i];
            in_b = b_t[i];
            in_tag = 4'(i + 3);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL directed_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != 3) begin
                n_err++; $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
            end
            n_cmp++;
            if (out_prod !== e_t[i] || out_prod !== model16(a_t[i], b_t[i])) begin
                n_err++; $display("FAIL directed_prod[%0d]: got %h want %h", i, out_prod, e_t[i]);
            end
            n_cmp++;
            if (out_tag !== 4'(i + 3)) begin
                n_err++; $display("FAIL directed_tag[%0d]: got %h want %h", i, out_tag, 4'(i + 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcvd = 0, it = 0, last_it = -1;
        exp_q.delete();
        tag_q.delete();
        out_ready = 1'b1;
        while (rcvd < 64 && it < 200) begin
            @(negedge clk);
            in_valid = (sent < 64);
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_tag = 4'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL stream_in_ready@%0d: got %b want 1", it, in_ready);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra@%0d: got %h want none", it, out_prod);
                end else begin
                    if (out_prod !== exp_q[0] || out_tag !== tag_q[0]) begin
                        n_err++;
                        $display("FAIL stream_result@%0d: got %h/%h want %h/%h",
                                 it, out_prod, out_tag, exp_q[0], tag_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(tag_q.pop_front());
                    rcvd++;
                    last_it = it;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model16(in_a, in_b));
                tag_q.push_back(in_tag);
                sent++;
            end
            it++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (rcvd != 64) begin
            n_err++; $display("FAIL stream_count: got %0d want 64", rcvd);
        end
        // 64 ops at one per cycle plus 3 cycles of latency.
        n_cmp++;
        if (last_it != 66) begin
            n_err++; $display("FAIL stream_throughput: last result at %0d want 66", last_it);
        end
    endtask

    task automatic test_backpressure();
        int sent = 0, rcvd = 0, it = 0;
        exp_q.delete();
        tag_q.delete();
        while (rcvd < 100 && it < 3000) begin
            @(negedge clk);
            in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_tag = 4'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_err++;
                $display("FAIL bp_in_ready@%0d: got %b want %b", it, in_ready,
                         !out_valid || out_ready);
            end
            // Front of the queue must be shown, held steady while stalled.
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL bp_extra@%0d: got %h want none", it, out_prod);
                end else begin
                    if (out_prod !== exp_q[0] || out_tag !== tag_q[0]) begin
                        n_err++;
                        $display("FAIL bp_result@%0d: got %h/%h want %h/%h",
                                 it, out_prod, out_tag, exp_q[0], tag_q[0]);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(tag_q.pop_front());
                        rcvd++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model16(in_a, in_b));
                tag_q.push_back(in_tag);
                sent++;
            end
            it++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (rcvd != 100 || exp_q.size() != 0) begin
            n_err++; $display("FAIL bp_count: got %0d (left %0d) want 100 (left 0)",
                              rcvd, exp_q.size());
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_no_dup: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0, lat;
        logic [15:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_tag = 4'(i);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 16'h0101;
        in_tag = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_prod !== 32'd0 || out_tag !== 4'd0) begin
            n_err++; $display("FAIL midrst_clear: got %b/%h/%h want 0/0/0",
                              out_valid, out_prod, out_tag);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL midrst_discarded: got %0d results want 0", seen);
        end
        a = 16'($urandom);
        b = 16'($urandom);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = 4'h9;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 3 || out_prod !== model16(a, b) || out_tag !== 4'h9) begin
            n_err++; $display("FAIL midrst_next_op: got lat %0d %h/%h want lat 3 %h/9",
                              lat, out_prod, out_tag, model16(a, b));
        end
    endtask

    task automatic test_operands_w8();
        logic [7:0]  a_t [5] = '{8'h80, 8'hFF, 8'h00, 8'hFF, 8'hFF};
        logic [7:0]  b_t [5] = '{8'h80, 8'h01, 8'hFB, 8'h01, 8'hFF};
        logic        s_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef VEDIC_SIGNED_EN
        logic [15:0] e_t [5] = '{16'h4000, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0001};
`else
        logic [15:0] e_t [5] = '{16'h4000, 16'h00FF, 16'h0000, 16'h00FF, 16'hFE01};
`endif
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] e;
        int lat;
        out_ready8 = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i < 5) begin
                a = a_t[i]; b = b_t[i]; s = s_t[i]; e = e_t[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); s = 1'($urandom); e = model8(a, b, s);
            end
            @(negedge clk);
            in_valid8 = 1'b1;
            in_a8 = a;
            in_b8 = b;
            in_signed8 = s;
            in_tag8 = 4'(i);
            @(posedge clk);
            @(negedge clk);
            in_valid8 = 1'b0;
            lat = 1;
            while (out_valid8 !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++;
            if (lat != 3 || out_prod8 !== e || out_tag8 !== 4'(i)) begin
                n_err++;
                $display("FAIL w8_case[%0d] %h*%h s=%b: got lat %0d %h tag %h want lat 3 %h tag %h",
                         i, a, b, s, lat, out_prod8, out_tag8, e, 4'(i));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; in_tag8 = '0;
        out_ready8 = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_operands_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
